// File: rtl/coherence_arbiter.sv
// coherence_arbiter
// Shares one single-ported RAM between two write-back data caches and keeps
// them coherent by snooping. One transaction is granted at a time, with
// round-robin priority between the caches.
//
// Ports:
//   CLK, nRST            clock (rising edge), synchronous active-low reset
//   dREN/dWEN[1:0]       per-cache read / write request
//   cctrans/ccwrite[1:0] per-cache coherence transaction / dirty indication
//   daddr/dstore[1:0]    per-cache address and store data
//   dwait[1:0]           stall to each cache
//   dload[1:0]           load data to each cache (unused lanes are 0)
//   ccwait/ccinv[1:0]    snoop request / snoop-is-invalidate to each cache
//   ccsnoopaddr[1:0]     snoop address to each cache
//   ramREN/ramWEN        RAM read / write strobes
//   ramaddr/ramstore     RAM address and write data
//   ramload, ram_ready   RAM read data, access completes this cycle
module coherence_arbiter #(
    parameter int unsigned WORD_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0]             cctrans,
    input  logic [1:0]             ccwrite,
    input  logic [1:0][WORD_W-1:0] daddr,
    input  logic [1:0][WORD_W-1:0] dstore,
    output logic [1:0]             dwait,
    output logic [1:0][WORD_W-1:0] dload,
    output logic [1:0]             ccwait,
    output logic [1:0]             ccinv,
    output logic [1:0][WORD_W-1:0] ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic                   ram_ready
);

    typedef enum logic [2:0] {IDLE, WB, SNOOP, CCWB, LOAD} state_t;

    state_t             state;
    logic               g;
    logic               last_grant;
    logic               beat;
    logic               is_inv;
    logic [WORD_W-1:0]  snp_addr;

    logic               o;
    logic [1:0]         req;
    logic               gn;

    assign o   = ~g;
    assign req = dREN | dWEN | cctrans;

    // On a tie the cache that did not win last time is granted.
    always_comb begin
        gn = req[1];
        if (req == 2'b11) begin
            gn = ~last_grant;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            g          <= 1'b0;
            last_grant <= 1'b1;
            beat       <= 1'b0;
            snp_addr   <= '0;
            is_inv     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        g          <= gn;
                        last_grant <= gn;
                        if (dWEN[gn]) begin
                            state <= WB;
                        end else if (cctrans[gn]) begin
                            state    <= SNOOP;
                            snp_addr <= daddr[gn];
                            is_inv   <= ~dREN[gn];
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                SNOOP: begin
                    if (cctrans[o]) begin
                        if (ccwrite[o]) begin
                            state <= CCWB;
                        end else if (is_inv) begin
                            state <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                WB, CCWB, LOAD: begin
                    // Two RAM beats per transaction; beat marks the second.
                    if (ram_ready) begin
                        beat <= ~beat;
                        if (beat) begin
                            beat <= 1'b0;
                            if (state == CCWB && !is_inv) begin
                                state <= LOAD;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[g];
                ramstore = dstore[g];
                dwait[g] = ~ram_ready;
            end
            SNOOP: begin
                ccwait[o]      = 1'b1;
                ccinv[o]       = is_inv;
                ccsnoopaddr[o] = snp_addr;
            end
            CCWB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[o];
                ramstore = dstore[o];
                dwait[o] = ~ram_ready;
            end
            LOAD: begin
                ramREN   = 1'b1;
                ramaddr  = daddr[g];
                dload[g] = ramload;
                dwait[g] = ~ram_ready;
            end
            default: ;
        endcase
    end

endmodule
